bcd_entry_conv: RTL and testbench
=================================

# bcd_entry_conv

Parametrised keypad-style decimal entry block for the calculator datapath, generalising the fixed three-digit button entry to DIGITS digits with optional sign.
- Single-cycle, already-debounced button pulses edit a BCD digit register under a movable cursor.
- A commit starts a multi-cycle BCD-to-binary conversion.
- The binary operand is presented on a valid/ready handshake to the operand/ALU stage.
- The live BCD digits drive the 7-segment display mux.

## Interface
- DIGITS, 4: number of BCD digits; 2..8.
- BIN_W, 14: binary magnitude width; must be ≥ ceil(log2(10^DIGITS)), otherwise the result is truncated mod 2^BIN_W.
- SIGNED, 0: 1 enables the sign toggle input.
- CLEAR_ON_ACCEPT, 1: 1 clears the digits and sign after a handshake completes.
- CLK100MHZ  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- inc, dec  in  1 each  one-cycle pulses; add or subtract 1 at the cursor digit.
- cur_left, cur_right  in  1 each  one-cycle pulses; move the cursor.
- neg  in  1  one-cycle pulse; toggles the sign. Ignored when SIGNED=0.
- clr  in  1  one-cycle pulse; clears the entry and aborts any conversion.
- commit  in  1  one-cycle pulse; starts conversion.
- out_ready  in  1  consumer ready.
- digits  out  4*DIGITS  BCD digits; digit 0 is least significant, at [3:0].
- cursor  out  clog2(DIGITS)  index of the editable digit.
- sign  out  1  1 = negative; always 0 when SIGNED=0.
- busy  out  1  high in CONVERT and HOLD.
- out_valid  out  1  result valid.
- out_bin  out  BIN_W  magnitude of the committed value.
- out_neg  out  1  sign of the committed value.

## Operation
- States: EDIT, CONVERT, HOLD. Reset enters EDIT.
- Reset values: digits=0, cursor=0, sign=0, busy=0, out_valid=0, out_bin=0, out_neg=0.
- Reset asserted mid-conversion or in HOLD forces the reset values immediately (asynchronously).
- EDIT, one action per cycle, priority clr > commit > inc > dec > neg > cur_left > cur_right. Lower-priority pulses in the same cycle are dropped.
  - inc: digit at cursor 9→0, else +1. No carry to neighbouring digits.
  - dec: digit at cursor 0→9, else −1. No borrow.
  - cur_left: cursor+1, wrapping DIGITS−1→0.
  - cur_right: cursor−1, wrapping 0→DIGITS−1.
  - neg: toggles sign when SIGNED=1.
  - clr: digits=0, sign=0, cursor=0.
  - commit: acc=0, idx=DIGITS−1, out_neg latches sign, go to CONVERT.
- CONVERT: each cycle acc ← acc*10 + digits[idx], then idx−1 (most significant digit first). All arithmetic is mod 2^BIN_W. After the idx=0 step, go to HOLD with out_bin=acc.
- A value of zero with sign=1 still reports out_neg=1. Normalisation is the consumer's job.
- HOLD: out_valid=1. out_bin and out_neg are stable until transfer.
- Transfer occurs on any edge where out_valid & out_ready are both high.
  - Go to EDIT.
  - If CLEAR_ON_ACCEPT=1: clear digits, sign and cursor. Otherwise retain them for re-editing.
- In CONVERT and HOLD, inc/dec/cur_*/neg/commit are ignored. digits stay frozen, so the display shows the committed value.
- clr in CONVERT or HOLD aborts:
  - next cycle: EDIT, entry cleared, out_valid=0, busy=0;
  - out_bin keeps its last value.
- Illegal stored digit codes are impossible: the only writers are inc, dec, clr and reset.

## Timing
- Edit actions take effect on the edge that samples the pulse and are visible on digits/cursor the following cycle.
- Commit sampled at edge E:
  - busy=1 from E;
  - CONVERT occupies edges E+1..E+DIGITS;
  - out_valid=1 after edge E+DIGITS.
- Commit-to-valid latency is DIGITS cycles. For DIGITS=4, valid is seen in the 5th cycle after the commit pulse cycle.
- out_ready may be held high before out_valid. The transfer then happens on the first edge with out_valid=1, and out_valid is high for exactly one cycle.
- With out_ready low, HOLD persists indefinitely and outputs do not change.
- A commit pulse in the same cycle as the transfer edge is ignored. A new commit is accepted from the first EDIT cycle onward.

## Test plan
- DIGITS=4: reset; 9×inc, cur_left, 9×inc, cur_left, 9×inc; commit.
  - Required: digits=0x0999, cursor=2.
  - busy rises the next cycle.
  - out_valid after 4 conversion cycles with out_bin=999; out_ready=1 → out_valid low next cycle and digits=0.
- Wrap: at cursor 0, dec from 0 → digit 9, then inc → 0. cur_right at cursor 0 → cursor 3; cur_left at 3 → 0. Neighbouring digits unchanged throughout.
- Backpressure: enter 1234 and commit with out_ready=0 for 20 cycles.
  - out_bin=1234 is held stable, and inc/commit pulses in HOLD change nothing.
  - Raising out_ready gives exactly one transfer.
- Abort: commit 9999, then clr on the 2nd CONVERT cycle. Next cycle: EDIT, digits=0, busy=0, out_valid never asserted.
- SIGNED=1, CLEAR_ON_ACCEPT=0, DIGITS=3: enter 500, neg, commit.
  - Required: out_bin=500, out_neg=1.
  - After accept, digits=0x500 and sign=1 are retained.
- Priority and reset: simultaneous clr+inc in EDIT → digits=0. Assert rst_n low asynchronously mid-CONVERT → all outputs at reset values before the next edge.

Source files
------------

// File: rtl/bcd_entry_conv_if.sv
// ---------------------------------------------------------------------------
// bcd_entry_conv_if
// Result handshake between the decimal entry block and the operand/ALU stage.
//   out_valid  : converted operand is present (producer -> consumer)
//   out_ready  : consumer can take the operand  (consumer -> producer)
//   out_bin    : binary magnitude of the committed entry, BIN_W bits
//   out_neg    : sign of the committed entry (1 = negative)
// BIN_W must match the BIN_W of the bcd_entry_conv instance it connects to.
// ---------------------------------------------------------------------------
interface bcd_entry_conv_if #(
  parameter int BIN_W = 14
);
  logic             out_valid;
  logic             out_ready;
  logic [BIN_W-1:0] out_bin;
  logic             out_neg;

  modport master (
    output out_valid,
    output out_bin,
    output out_neg,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_bin,
    input  out_neg,
    output out_ready
  );
endinterface

// File: rtl/bcd_entry_conv.sv
// ---------------------------------------------------------------------------
// bcd_entry_conv
// Keypad-style decimal entry: debounced button pulses edit a BCD digit
// register under a movable cursor; commit converts the digits to binary
// (most significant digit first, one digit per cycle) and offers the result
// on a valid/ready handshake.
//
// Ports
//   CLK100MHZ             system clock, rising edge
//   rst_n                 asynchronous active-low reset
//   inc, dec              +1 / -1 at the cursor digit, wrapping 9<->0
//   cur_left, cur_right   move cursor towards MSD / LSD, wrapping
//   neg                   toggle sign (only when SIGNED=1)
//   clr                   clear entry, abort any conversion
//   commit                start conversion
//   digits                live BCD digits, digit 0 in [3:0]
//   cursor                index of the editable digit
//   sign                  entry sign (1 = negative)
//   busy                  conversion running or result waiting
//   bus (master)          out_valid / out_ready / out_bin / out_neg
// ---------------------------------------------------------------------------
module bcd_entry_conv #(
  parameter  int DIGITS          = 4,
  parameter  int BIN_W           = 14,
  parameter  bit SIGNED          = 1'b0,
  parameter  bit CLEAR_ON_ACCEPT = 1'b1,
  localparam int CUR_W           = $clog2(DIGITS)
) (
  input  logic                 CLK100MHZ,
  input  logic                 rst_n,
  input  logic                 inc,
  input  logic                 dec,
  input  logic                 cur_left,
  input  logic                 cur_right,
  input  logic                 neg,
  input  logic                 clr,
  input  logic                 commit,
  output logic [4*DIGITS-1:0]  digits,
  output logic [CUR_W-1:0]     cursor,
  output logic                 sign,
  output logic                 busy,
  bcd_entry_conv_if.master     bus
);

  typedef enum logic [1:0] {
    EDIT,
    CONVERT,
    HOLD
  } stateT;

  localparam logic [CUR_W-1:0] LAST_IDX = CUR_W'(DIGITS - 1);

  stateT                   state,    stateNext;
  logic [DIGITS-1:0][3:0]  digitReg, digitNext;
  logic [CUR_W-1:0]        cursorReg, cursorNext;
  logic                    signReg,  signNext;
  logic [BIN_W-1:0]        acc,      accNext;
  logic [CUR_W-1:0]        idx,      idxNext;
  logic [BIN_W-1:0]        outBin,   outBinNext;
  logic                    outNeg,   outNegNext;

  logic [3:0]              curDigit;
  logic [3:0]              idxDigit;
  logic                    clearEntry;

  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so
    // no path through the case leaves a signal unassigned (no latches).
    stateNext  = state;
    digitNext  = digitReg;
    cursorNext = cursorReg;
    signNext   = signReg;
    accNext    = acc;
    idxNext    = idx;
    outBinNext = outBin;
    outNegNext = outNeg;
    clearEntry = 1'b0;
    curDigit   = digitReg[cursorReg];
    idxDigit   = digitReg[idx];

    unique case (state)
      EDIT: begin
        // One action per cycle; the if-chain order is the button priority.
        if (clr) begin
          clearEntry = 1'b1;
        end else if (commit) begin
          accNext    = '0;
          idxNext    = LAST_IDX;
          outNegNext = signReg;
          stateNext  = CONVERT;
        end else if (inc) begin
          digitNext[cursorReg] = (curDigit == 4'd9) ? 4'd0 : curDigit + 4'd1;
        end else if (dec) begin
          digitNext[cursorReg] = (curDigit == 4'd0) ? 4'd9 : curDigit - 4'd1;
        end else if (neg && SIGNED) begin
          signNext = ~signReg;
        end else if (cur_left) begin
          cursorNext = (cursorReg == LAST_IDX) ? '0 : cursorReg + CUR_W'(1);
        end else if (cur_right) begin
          cursorNext = (cursorReg == '0) ? LAST_IDX : cursorReg - CUR_W'(1);
        end
      end

      CONVERT: begin
        if (clr) begin
          clearEntry = 1'b1;
          stateNext  = EDIT;
        end else begin
          // Horner step: acc*10 = acc*8 + acc*2, wrapping at BIN_W bits.
          accNext = (acc << 3) + (acc << 1) + BIN_W'(idxDigit);
          idxNext = idx - CUR_W'(1);
          if (idx == '0) begin
            outBinNext = accNext;
            stateNext  = HOLD;
          end
        end
      end

      HOLD: begin
        if (clr) begin
          clearEntry = 1'b1;
          stateNext  = EDIT;
        end else if (bus.out_ready) begin
          stateNext  = EDIT;
          clearEntry = CLEAR_ON_ACCEPT;
        end
      end

      default: stateNext = EDIT;
    endcase

    // Abort and accept-with-clear share the same entry wipe; out_bin is
    // deliberately untouched so the last result stays observable.
    if (clearEntry) begin
      digitNext  = '0;
      signNext   = 1'b0;
      cursorNext = '0;
    end
  end

  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EDIT;
      digitReg  <= '0;
      cursorReg <= '0;
      signReg   <= 1'b0;
      acc       <= '0;
      idx       <= '0;
      outBin    <= '0;
      outNeg    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state     <= stateNext;
      digitReg  <= digitNext;
      cursorReg <= cursorNext;
      signReg   <= signNext;
      acc       <= accNext;
      idx       <= idxNext;
      outBin    <= outBinNext;
      outNeg    <= outNegNext;
    end
  end

  assign digits        = digitReg;
  assign cursor        = cursorReg;
  assign sign          = signReg;
  assign busy          = (state != EDIT);
  assign bus.out_valid = (state == HOLD);
  assign bus.out_bin   = outBin;
  assign bus.out_neg   = outNeg;

endmodule

// File: tb/tb_bcd_entry_conv.sv
// ---------------------------------------------------------------------------
// tb_bcd_entry_conv
// Two instances: A = 4 digits, 14-bit, unsigned, clear on accept;
//                B = 3 digits, 9-bit (999 wraps), signed, retain on accept.
// The reference model keeps the entry as an integer digit array and computes
// the committed value as sum(d[i]*10^i) mod 2^BIN_W. Commits push the
// expected result into a queue; a monitor pops it on every handshake.
// ---------------------------------------------------------------------------
module tb_bcd_entry_conv;
  localparam int DA = 4, WA = 14, DB = 3, WB = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic incP[2], decP[2], leftP[2], rightP[2], negP[2], clrP[2], commitP[2];

  logic [4*DA-1:0] digitsA;
  logic [1:0]      cursorA;
  logic            signA, busyA;
  logic [4*DB-1:0] digitsB;
  logic [1:0]      cursorB;
  logic            signB, busyB;

  bcd_entry_conv_if #(.BIN_W(WA)) busA ();
  bcd_entry_conv_if #(.BIN_W(WB)) busB ();

  bcd_entry_conv #(.DIGITS(DA), .BIN_W(WA), .SIGNED(1'b0), .CLEAR_ON_ACCEPT(1'b1)) dutA (
    .CLK100MHZ(clk), .rst_n(rst_n), .inc(incP[0]), .dec(decP[0]),
    .cur_left(leftP[0]), .cur_right(rightP[0]), .neg(negP[0]), .clr(clrP[0]),
    .commit(commitP[0]), .digits(digitsA), .cursor(cursorA), .sign(signA),
    .busy(busyA), .bus(busA.master));

  bcd_entry_conv #(.DIGITS(DB), .BIN_W(WB), .SIGNED(1'b1), .CLEAR_ON_ACCEPT(1'b0)) dutB (
    .CLK100MHZ(clk), .rst_n(rst_n), .inc(incP[1]), .dec(decP[1]),
    .cur_left(leftP[1]), .cur_right(rightP[1]), .neg(negP[1]), .clr(clrP[1]),
    .commit(commitP[1]), .digits(digitsB), .cursor(cursorB), .sign(signB),
    .busy(busyB), .bus(busB.master));

  typedef struct packed { logic [31:0] bin; logic neg; } exp_t;
  typedef enum { P_INC, P_DEC, P_LEFT, P_RIGHT, P_NEG, P_CLR, P_COMMIT, P_IDLE } act_t;

  exp_t expA[$];
  exp_t expB[$];
  int   total = 0;
  int   bad = 0;
  int   xfer[2];
  logic [31:0] lastBin[2];

  // Reference model state
  int mDig[2][8];
  int mCur[2];
  bit mSign[2];

  function automatic int nd(int s);  return (s == 0) ? DA : DB; endfunction
  function automatic int bw(int s);  return (s == 0) ? WA : WB; endfunction

  task automatic check(string name, logic [63:0] actual, logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic void modelClear(int s);
    for (int i = 0; i < 8; i++) mDig[s][i] = 0;
    mCur[s]  = 0;
    mSign[s] = 1'b0;
  endfunction

  function automatic logic [31:0] modelValue(int s);
    longint v = 0;
    longint p = 1;
    for (int i = 0; i < nd(s); i++) begin
      v += mDig[s][i] * p;
      p *= 10;
    end
    return 32'(v % (longint'(1) << bw(s)));
  endfunction

  function automatic logic [31:0] modelPacked(int s);
    logic [31:0] v = '0;
    for (int i = 0; i < nd(s); i++) v[i*4 +: 4] = 4'(mDig[s][i]);
    return v;
  endfunction

  function automatic void modelEdit(int s, bit c, bit cm, bit i, bit d, bit n, bit l, bit r);
    exp_t e;
    if (c) modelClear(s);
    else if (cm) begin
      e.bin = modelValue(s);
      e.neg = mSign[s];
      if (s == 0) expA.push_back(e); else expB.push_back(e);
    end
    else if (i) mDig[s][mCur[s]] = (mDig[s][mCur[s]] + 1) % 10;
    else if (d) mDig[s][mCur[s]] = (mDig[s][mCur[s]] + 9) % 10;
    else if (n && s == 1) mSign[s] = !mSign[s];
    else if (l) mCur[s] = (mCur[s] + 1) % nd(s);
    else if (r) mCur[s] = (mCur[s] + nd(s) - 1) % nd(s);
  endfunction

  function automatic logic [31:0] getDigits(int s); return (s == 0) ? 32'(digitsA) : 32'(digitsB); endfunction
  function automatic logic [31:0] getCursor(int s); return (s == 0) ? 32'(cursorA) : 32'(cursorB); endfunction
  function automatic logic getSign(int s);  return (s == 0) ? signA : signB; endfunction
  function automatic logic getBusy(int s);  return (s == 0) ? busyA : busyB; endfunction
  function automatic logic getValid(int s); return (s == 0) ? busA.out_valid : busB.out_valid; endfunction
  function automatic logic getNeg(int s);   return (s == 0) ? busA.out_neg : busB.out_neg; endfunction
  function automatic logic [31:0] getBin(int s); return (s == 0) ? 32'(busA.out_bin) : 32'(busB.out_bin); endfunction

  task automatic setReady(int s, logic v);
    if (s == 0) busA.out_ready = v; else busB.out_ready = v;
  endtask

  // Drive a set of pulses for exactly one edge; returns 1 time unit after it.
  task automatic step(int s, bit c, bit cm, bit i, bit d, bit n, bit l, bit r, bit track);
    clrP[s] = c; commitP[s] = cm; incP[s] = i; decP[s] = d;
    negP[s] = n; leftP[s] = l; rightP[s] = r;
    @(posedge clk); #1;
    clrP[s] = 0; commitP[s] = 0; incP[s] = 0; decP[s] = 0;
    negP[s] = 0; leftP[s] = 0; rightP[s] = 0;
    if (track) modelEdit(s, c, cm, i, d, n, l, r);
  endtask

  task automatic press(int s, act_t a);
    step(s, a == P_CLR, a == P_COMMIT, a == P_INC, a == P_DEC, a == P_NEG,
         a == P_LEFT, a == P_RIGHT, 1'b1);
  endtask

  task automatic checkModel(int s, string tag);
    check({tag, " digits"}, getDigits(s), modelPacked(s));
    check({tag, " cursor"}, getCursor(s), 32'(mCur[s]));
    check({tag, " sign"},   getSign(s),   mSign[s]);
  endtask

  // Enter a decimal value starting from cursor 0; cursor ends back at 0.
  task automatic enter(int s, int value);
    int v = value;
    for (int i = 0; i < nd(s); i++) begin
      repeat (v % 10) press(s, P_INC);
      press(s, P_LEFT);
      v /= 10;
    end
  endtask

  // Cycles from the commit edge until out_valid is seen (bounded).
  task automatic waitValid(int s, int maxCycles, output int n);
    n = 0;
    while (n < maxCycles) begin
      @(posedge clk); #1;
      n++;
      if (getValid(s)) break;
    end
  endtask

  task automatic doTransfer(int s);
    setReady(s, 1'b1);
    @(posedge clk); #1;
    setReady(s, 1'b0);
    if (s == 0) modelClear(s);
  endtask

  task automatic monitorOne(int s);
    exp_t e;
    int   sz;
    sz = (s == 0) ? expA.size() : expB.size();
    if (sz == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected transfer on dut%0d: out_bin=0x%0h, no result pending", s, getBin(s));
    end else begin
      e = (s == 0) ? expA.pop_front() : expB.pop_front();
      check($sformatf("scoreboard dut%0d out_bin", s), getBin(s), e.bin);
      check($sformatf("scoreboard dut%0d out_neg", s), getNeg(s), e.neg);
      lastBin[s] = e.bin;
    end
    xfer[s]++;
  endtask

  always @(negedge clk) begin
    if (rst_n && busA.out_valid && busA.out_ready) monitorOne(0);
    if (rst_n && busB.out_valid && busB.out_ready) monitorOne(1);
  end

  task automatic randomRun(int s, int nTrans);
    int  saw;
    for (int t = 0; t < nTrans; t++) begin
      repeat ($urandom_range(1, 10)) begin
        step(s, $urandom_range(0, 15) == 0, 1'b0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, 1'b1);
        checkModel(s, $sformatf("rand dut%0d", s));
      end
      step(s, 1'b0, 1'b1, $urandom_range(0, 1) == 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      saw = 0;
      for (int k = 0; k < 60 && saw == 0; k++) begin
        setReady(s, $urandom_range(0, 1) == 1);
        @(negedge clk);
        if (getValid(s) && ((s == 0) ? busA.out_ready : busB.out_ready)) saw = 1;
        @(posedge clk); #1;
      end
      setReady(s, 1'b0);
      check($sformatf("rand dut%0d transfer seen", s), saw, 1);
      if (s == 0) modelClear(s);
      check($sformatf("rand dut%0d busy after xfer", s), getBusy(s), 1'b0);
      checkModel(s, $sformatf("rand dut%0d post-xfer", s));
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cnt, stableBad, x0;
    for (int s = 0; s < 2; s++) begin
      incP[s] = 0; decP[s] = 0; leftP[s] = 0; rightP[s] = 0;
      negP[s] = 0; clrP[s] = 0; commitP[s] = 0;
      xfer[s] = 0; lastBin[s] = '0;
      modelClear(s);
    end
    busA.out_ready = 1'b0;
    busB.out_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset digits", getDigits(0), 0);
    check("reset cursor", getCursor(0), 0);
    check("reset sign", getSign(0), 0);
    check("reset busy", getBusy(0), 0);
    check("reset out_valid", getValid(0), 0);
    check("reset out_bin", getBin(0), 0);
    check("reset out_neg", getNeg(0), 0);
    rst_n = 1'b1;

    // 999 entry and conversion latency
    repeat (9) press(0, P_INC);
    press(0, P_LEFT);
    repeat (9) press(0, P_INC);
    press(0, P_LEFT);
    repeat (9) press(0, P_INC);
    check("999 digits", getDigits(0), 32'h0999);
    check("999 cursor", getCursor(0), 2);
    checkModel(0, "999");
    press(0, P_COMMIT);
    check("999 busy after commit", getBusy(0), 1'b1);
    waitValid(0, 20, n);
    check("999 latency", n, DA);
    check("999 out_bin", getBin(0), 999);
    check("999 digits frozen", getDigits(0), 32'h0999);
    doTransfer(0);
    check("999 valid after xfer", getValid(0), 1'b0);
    check("999 digits cleared", getDigits(0), 0);
    check("999 xfer count", xfer[0], 1);

    // Digit and cursor wrap; neighbour digit must stay untouched
    press(0, P_LEFT);
    repeat (5) press(0, P_INC);
    press(0, P_RIGHT);
    press(0, P_DEC);
    check("wrap dec 0->9", getDigits(0), 32'h0059);
    press(0, P_INC);
    check("wrap inc 9->0", getDigits(0), 32'h0050);
    press(0, P_RIGHT);
    check("wrap cursor 0->3", getCursor(0), 3);
    press(0, P_LEFT);
    check("wrap cursor 3->0", getCursor(0), 0);
    checkModel(0, "wrap");

    // clr beats inc in the same cycle
    step(0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("prio clr+inc digits", getDigits(0), 0);

    // Backpressure: 1234 held while ignored pulses arrive
    enter(0, 1234);
    check("1234 digits", getDigits(0), 32'h1234);
    press(0, P_COMMIT);
    waitValid(0, 20, n);
    check("1234 valid", getValid(0), 1'b1);
    stableBad = 0;
    for (int k = 0; k < 20; k++) begin
      step(0, 1'b0, k[0], !k[0], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (getBin(0) !== 32'd1234 || getValid(0) !== 1'b1 || getDigits(0) !== 32'h1234)
        stableBad++;
    end
    check("hold stable under backpressure", stableBad, 0);
    x0 = xfer[0];
    setReady(0, 1'b1);
    commitP[0] = 1'b1;
    @(posedge clk); #1;
    commitP[0] = 1'b0;
    setReady(0, 1'b0);
    modelClear(0);
    check("1234 single transfer", xfer[0] - x0, 1);
    check("commit on xfer edge ignored", getBusy(0), 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("still idle after xfer", getBusy(0), 1'b0);
    check("1234 cleared", getDigits(0), 0);

    // Ready held high before valid: exactly one valid cycle
    enter(0, 42);
    setReady(0, 1'b1);
    press(0, P_COMMIT);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (getValid(0)) cnt++;
    end
    @(posedge clk); #1;
    setReady(0, 1'b0);
    modelClear(0);
    check("early ready valid cycles", cnt, 1);

    // Abort on the 2nd CONVERT cycle
    for (int i = 0; i < DA; i++) begin
      press(0, P_DEC);
      press(0, P_LEFT);
    end
    check("9999 digits", getDigits(0), 32'h9999);
    press(0, P_COMMIT);
    void'(expA.pop_back());
    press(0, P_IDLE);
    press(0, P_CLR);
    check("abort busy", getBusy(0), 1'b0);
    check("abort valid", getValid(0), 1'b0);
    check("abort digits", getDigits(0), 0);
    check("abort keeps out_bin", getBin(0), lastBin[0]);
    x0 = xfer[0];
    setReady(0, 1'b1);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (getValid(0)) cnt++;
    end
    @(posedge clk); #1;
    setReady(0, 1'b0);
    check("abort valid never seen", cnt, 0);
    check("abort no transfer", xfer[0] - x0, 0);

    randomRun(0, 30);

    // Signed, retain-on-accept instance: -500
    press(1, P_RIGHT);
    repeat (5) press(1, P_INC);
    press(1, P_NEG);
    check("B 500 digits", getDigits(1), 32'h500);
    check("B sign set", getSign(1), 1'b1);
    press(1, P_COMMIT);
    waitValid(1, 20, n);
    check("B latency", n, DB);
    check("B out_bin", getBin(1), 500);
    check("B out_neg", getNeg(1), 1'b1);
    doTransfer(1);
    check("B retained digits", getDigits(1), 32'h500);
    check("B retained sign", getSign(1), 1'b1);
    check("B retained cursor", getCursor(1), 2);

    // Negative zero is reported as-is
    press(1, P_CLR);
    press(1, P_NEG);
    press(1, P_COMMIT);
    waitValid(1, 20, n);
    check("B -0 out_bin", getBin(1), 0);
    check("B -0 out_neg", getNeg(1), 1'b1);
    doTransfer(1);

    randomRun(1, 30);

    // Asynchronous reset mid-conversion
    modelClear(0);
    enter(0, 77);
    press(0, P_COMMIT);
    press(0, P_IDLE);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst digits", getDigits(0), 0);
    check("async rst cursor", getCursor(0), 0);
    check("async rst busy", getBusy(0), 1'b0);
    check("async rst valid", getValid(0), 1'b0);
    check("async rst out_bin", getBin(0), 0);
    check("async rst out_neg", getNeg(0), 1'b0);
    check("async rst B digits", getDigits(1), 0);
    check("async rst B sign", getSign(1), 1'b0);
    void'(expA.pop_back());
    modelClear(0);
    modelClear(1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post-reset idle", getBusy(0), 1'b0);

    check("queue A drained", expA.size(), 0);
    check("queue B drained", expB.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
